// File: rtl/bch_pkg.sv
// GF(2^13) field definitions and constant helpers shared by the BCH decoder blocks.
// Pure package: no latency, no flow control.
// Field helpers are elaboration-time or combinational only.
package bch_pkg;
  localparam int BCH_M = 13;
  localparam logic [12:0] BCH_POLY = 13'h001B;
  localparam int GF_ORDER = 8191;

  typedef logic [BCH_M-1:0] gf_elem_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_HOLD} bch_state_t;

  function automatic gf_elem_t gf_mul_alpha(gf_elem_t x);
    return {x[BCH_M-2:0], 1'b0} ^ (x[BCH_M-1] ? BCH_POLY : '0);
  endfunction

  function automatic gf_elem_t gf_alpha_pow(int k);
    gf_elem_t r;
    int e;
    e = k % GF_ORDER;
    r = gf_elem_t'(1);
    for (int i = 0; i < e; i++) r = gf_mul_alpha(r);
    return r;
  endfunction

  function automatic gf_elem_t gf_square(gf_elem_t x);
    gf_elem_t r;
    r = '0;
    for (int i = BCH_M - 1; i >= 0; i--) r = gf_mul_alpha(r) ^ (x[i] ? x : '0);
    return r;
  endfunction

  function automatic gf_elem_t gf_square_n(gf_elem_t x, int n);
    gf_elem_t r;
    r = x;
    for (int i = 0; i < n; i++) r = gf_square(r);
    return r;
  endfunction

  // Number of factors of two in j; S_j = S_(j>>n)^(2^n) for binary codes.
  function automatic int trailing_twos(int j);
    int n;
    int v;
    n = 0;
    v = j;
    while (v > 0 && v % 2 == 0) begin
      v = v / 2;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/bch_gf_mul_const.sv
// Multiply a GF(2^13) element by the constant alpha^POWER as a fixed XOR matrix.
// Latency: combinational.
// Backpressure: none.
module bch_gf_mul_const
  import bch_pkg::*;
#(
  parameter int POWER = 1
) (
  input  gf_elem_t din,
  output gf_elem_t dout
);
  gf_elem_t cols [BCH_M];

  // Column i of the matrix is alpha^(POWER+i), the image of basis element x^i.
  for (genvar i = 0; i < BCH_M; i++) begin : g_col
    localparam gf_elem_t COL = gf_alpha_pow(POWER + i);
    assign cols[i] = din[i] ? COL : '0;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < BCH_M; i++) dout = dout ^ cols[i];
  end
endmodule

// File: rtl/bch_syndrome_calc.sv
// Bit-serial BCH syndrome generator (S1..S2T by Horner); BCH_SYND_EVEN_SQUARE_EN derives even S from odd.
// Latency: out_valid the cycle after the N-th accepted bit.
// Backpressure: in_ready low while the result waits in HOLD for out_ready.
module bch_syndrome_calc
  import bch_pkg::*;
#(
  parameter int M = 13,
  parameter int T = 8,
  parameter int N = 8191
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*T*M-1:0]     syndromes,
  output logic                 err_flag,
  output logic                 busy
);
  localparam int CW = $clog2(N + 1);
`ifdef BCH_SYND_EVEN_SQUARE_EN
  localparam int NREG = T;
`else
  localparam int NREG = 2 * T;
`endif

  bch_state_t      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            accept, last_bit, any_nz, err_q;
  gf_elem_t        syn_q [NREG];
  gf_elem_t        prod  [NREG];
  gf_elem_t        syn_d [NREG];

  assign cnt_inc  = cnt + CW'(1);
  assign last_bit = (cnt_inc == CW'(N));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ST_ACC;
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_bit) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar r = 0; r < NREG; r++) begin : g_reg
`ifdef BCH_SYND_EVEN_SQUARE_EN
    localparam int POW = 2 * r + 1;
`else
    localparam int POW = r + 1;
`endif
    bch_gf_mul_const #(.POWER(POW % GF_ORDER)) u_mul (
      .din  (syn_q[r]),
      .dout (prod[r])
    );
    // First bit of a block drops the product so stale syndromes never leak in.
    assign syn_d[r] = ((state == ST_IDLE) ? '0 : prod[r]) ^ gf_elem_t'(in_bit);
  end

  always_comb begin
    any_nz = 1'b0;
    for (int r = 0; r < NREG; r++) any_nz = any_nz | (|syn_d[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) syn_q[r] <= '0;
    end else if (accept) begin
      cnt <= last_bit ? '0 : cnt_inc;
      for (int r = 0; r < NREG; r++) syn_q[r] <= syn_d[r];
      if (last_bit) err_q <= any_nz;
    end
  end

`ifdef BCH_SYND_EVEN_SQUARE_EN
  for (genvar j = 1; j <= 2 * T; j++) begin : g_out
    localparam int SQ  = trailing_twos(j);
    localparam int ODD = j >> SQ;
    assign syndromes[(j-1)*M +: M] = gf_square_n(syn_q[(ODD-1)/2], SQ);
  end
`else
  for (genvar j = 0; j < 2 * T; j++) begin : g_out
    assign syndromes[j*M +: M] = syn_q[j];
  end
`endif

  assign err_flag = err_q;
endmodule

// File: tb/tb_bch_syndrome_calc.sv
// Bench for bch_syndrome_calc: vector table of whole codewords, scoreboard on the output handshake.
module tb_bch_syndrome_calc;
  localparam int M  = 13;
  localparam int T  = 8;
  localparam int N  = 8191;
  localparam int SW = 2 * T * M;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] syndromes;
  logic          err_flag;
  logic          busy;

  always #5 clk = ~clk;

  bch_syndrome_calc #(.M(M), .T(T), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .syndromes (syndromes),
    .err_flag  (err_flag),
    .busy      (busy)
  );

  typedef struct {
    int            kind;      // 0 zero, 1 r0=1, 2 r1=1, 3 random
    int            gap_pct;
    int            hold_cyc;
    logic [SW-1:0] exp_syn;
    logic          exp_err;
  } vec_t;

  typedef struct {
    int            id;
    logic [SW-1:0] syn;
    logic          err;
  } exp_t;

  localparam logic [12:0] R1_EXP [16] = '{
    13'h0002, 13'h0004, 13'h0008, 13'h0010, 13'h0020, 13'h0040, 13'h0080, 13'h0100,
    13'h0200, 13'h0400, 13'h0800, 13'h1000, 13'h001B, 13'h0036, 13'h006C, 13'h00D8
  };

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  exp_t mon_e;
  bit   cw [N];
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Schoolbook product then reduction by x^13+x^4+x^3+x+1.
  function automatic logic [12:0] m_mul(input logic [12:0] a, input logic [12:0] b);
    logic [24:0] p;
    p = '0;
    for (int i = 0; i < 13; i++) if (b[i]) p = p ^ (25'(a) << i);
    for (int k = 24; k >= 13; k--) if (p[k]) p = p ^ (25'h201B << (k - 13));
    return p[12:0];
  endfunction

  function automatic logic [SW-1:0] model_syn();
    logic [SW-1:0] res;
    logic [12:0]   step, a, s;
    res = '0;
    for (int j = 1; j <= 2 * T; j++) begin
      step = 13'h0001;
      for (int k = 0; k < j; k++) step = m_mul(step, 13'h0002);
      a = 13'h0001;
      s = '0;
      for (int i = 0; i < N; i++) begin
        if (cw[i]) s = s ^ a;
        a = m_mul(a, step);
      end
      res[(j-1)*M +: M] = s;
    end
    return res;
  endfunction

  task automatic run_block(input vec_t v, input int id);
    exp_t e;
    int   sent;
    int   cyc;
    logic acc;
    for (int i = 0; i < N; i++) begin
      case (v.kind)
        1:       cw[i] = (i == 0);
        2:       cw[i] = (i == 1);
        3:       cw[i] = 1'($urandom_range(0, 1));
        default: cw[i] = 1'b0;
      endcase
    end
    if (v.kind == 3) begin
      v.exp_syn = model_syn();
      v.exp_err = |v.exp_syn;
    end
    e.id = id;
    e.syn = v.exp_syn;
    e.err = v.exp_err;
    sb.push_back(e);
    if (v.hold_cyc == 0) out_ready = 1'b1;
    sent = 0;
    cyc = 0;
    while (sent < N && cyc < 4 * N) begin
      in_valid = (v.gap_pct == 0) || ($urandom_range(0, 99) >= v.gap_pct);
      in_bit = cw[N-1-sent];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc && sent == N - 1) chk($sformatf("blk%0d out_valid before last", id), out_valid, 0);
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (v.hold_cyc > 0) out_ready = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (sent != N) chk($sformatf("blk%0d accept budget", id), sent, N);
    chk($sformatf("blk%0d out_valid latency", id), out_valid, 1);
    chk($sformatf("blk%0d in_ready in hold", id), in_ready, 0);
    if (v.hold_cyc > 0) begin
      for (int k = 0; k < v.hold_cyc; k++) begin
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(negedge clk);
        chk($sformatf("blk%0d held syndromes c%0d", id, k), syndromes, v.exp_syn);
        chk($sformatf("blk%0d held err c%0d", id, k), err_flag, v.exp_err);
        chk($sformatf("blk%0d held in_ready c%0d", id, k), in_ready, 0);
        chk($sformatf("blk%0d held out_valid c%0d", id, k), out_valid, 1);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("blk%0d out_valid after handshake", id), out_valid, 0);
      chk($sformatf("blk%0d in_ready after handshake", id), in_ready, 1);
      chk($sformatf("blk%0d busy after handshake", id), busy, 0);
      chk($sformatf("blk%0d syndromes kept after handshake", id), syndromes, v.exp_syn);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected out_valid", out_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        for (int j = 1; j <= 2 * T; j++)
          chk($sformatf("blk%0d S%0d", mon_e.id, j), syndromes[(j-1)*M +: M], mon_e.syn[(j-1)*M +: M]);
        chk($sformatf("blk%0d err_flag", mon_e.id), err_flag, mon_e.err);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] r0_syn;
    logic [SW-1:0] r1_syn;
    int            sent;
    int            cyc;
    for (int j = 0; j < 2 * T; j++) begin
      r0_syn[j*M +: M] = 13'h0001;
      r1_syn[j*M +: M] = R1_EXP[j];
    end
    vecs[0] = '{kind: 0, gap_pct: 0,  hold_cyc: 0, exp_syn: '0,     exp_err: 1'b0};
    vecs[1] = '{kind: 1, gap_pct: 0,  hold_cyc: 5, exp_syn: r0_syn, exp_err: 1'b1};
    vecs[2] = '{kind: 2, gap_pct: 0,  hold_cyc: 0, exp_syn: r1_syn, exp_err: 1'b1};
    vecs[3] = '{kind: 3, gap_pct: 30, hold_cyc: 0, exp_syn: '0,     exp_err: 1'b0};
    vecs[4] = '{kind: 3, gap_pct: 0,  hold_cyc: 2, exp_syn: '0,     exp_err: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset err_flag", err_flag, 0);
    chk("reset syndromes", syndromes, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) run_block(vecs[i], i);

    // Abort a block at bit 100 with an asynchronous reset.
    for (int i = 0; i < N; i++) cw[i] = 1'($urandom_range(0, 1));
    cw[N-1] = 1'b1;
    sent = 0;
    cyc = 0;
    while (sent < 100 && cyc < 1000) begin
      in_valid = 1'b1;
      in_bit = cw[N-1-sent];
      @(negedge clk);
      if (in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("partial block busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid-block reset in_ready", in_ready, 1);
    chk("mid-block reset out_valid", out_valid, 0);
    chk("mid-block reset busy", busy, 0);
    chk("mid-block reset err_flag", err_flag, 0);
    chk("mid-block reset syndromes", syndromes, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_block(vecs[4], 4);

    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("scoreboard drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
